// File: rtl/register_file_ab.sv
// Dual-read, single-write register file with registered read ports and
// write-to-read bypass; optional hard-wired zero register.
module register_file_ab #(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RW,
    input  logic [ADDR_W-1:0] DA,
    input  logic [WIDTH-1:0]  D_data,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    input  logic              HOLD,
    output logic [WIDTH-1:0]  A_data,
    output logic [WIDTH-1:0]  B_data
);

    localparam int NREG = 1 << ADDR_W;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] a_data_q, a_data_d;
    logic [WIDTH-1:0] b_data_q, b_data_d;
    logic             wr_en;
    logic             zero_a, zero_b;

    assign zero_a = (ZERO_R0 != 0) && (AA == '0);
    assign zero_b = (ZERO_R0 != 0) && (BA == '0);
    assign wr_en  = RW && !((ZERO_R0 != 0) && (DA == '0));

    // Bypass gives the in-flight write priority over the stored value.
    always_comb begin
        a_data_d = regs_q[AA];
        b_data_d = regs_q[BA];
        if (wr_en && (DA == AA)) a_data_d = D_data;
        if (wr_en && (DA == BA)) b_data_d = D_data;
        if (zero_a) a_data_d = '0;
        if (zero_b) b_data_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            if (wr_en) regs_q[DA] <= D_data;
            if (!HOLD) begin
                a_data_q <= a_data_d;
                b_data_q <= b_data_d;
            end
        end
    end

    assign A_data = a_data_q;
    assign B_data = b_data_q;

endmodule

// File: tb/tb_register_file_ab.sv
// Directed bench for register_file_ab: one default instance and one with
// register 0 hard-wired to zero, both driven by the same stimulus.
module tb_register_file_ab;

    logic        clk;
    logic        rst;
    logic        RW;
    logic [2:0]  DA;
    logic [15:0] D_data;
    logic [2:0]  AA;
    logic [2:0]  BA;
    logic        HOLD;
    logic [15:0] A_data, B_data;
    logic [15:0] A_data_z, B_data_z;

    int checks = 0;
    int errors = 0;

    register_file_ab #(.WIDTH(16), .ADDR_W(3), .ZERO_R0(0)) dut (
        .clk(clk), .rst(rst), .RW(RW), .DA(DA), .D_data(D_data),
        .AA(AA), .BA(BA), .HOLD(HOLD), .A_data(A_data), .B_data(B_data)
    );

    register_file_ab #(.WIDTH(16), .ADDR_W(3), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst), .RW(RW), .DA(DA), .D_data(D_data),
        .AA(AA), .BA(BA), .HOLD(HOLD), .A_data(A_data_z), .B_data(B_data_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] ea, eb;
        rst = 1'b0; RW = 1'b0; DA = '0; D_data = '0; AA = '0; BA = '0; HOLD = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("por_a", A_data, 16'h0000);
        check("por_b", B_data, 16'h0000);
        check("por_za", A_data_z, 16'h0000);
        tick();
        rst = 1'b0;

        // Reset clears stored data between edges
        RW = 1'b1; DA = 3'd3; D_data = 16'h1234; AA = 3'd3; BA = 3'd3;
        tick();
        check("r3_bypass_a", A_data, 16'h1234);
        check("r3_bypass_b", B_data, 16'h1234);
        RW = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_async_a", A_data, 16'h0000);
        check("rst_async_b", B_data, 16'h0000);
        rst = 1'b0;
        tick();
        check("rst_r3_cleared", A_data, 16'h0000);

        // Write then read: one-cycle latency
        RW = 1'b1; DA = 3'd5; D_data = 16'hBEEF; AA = 3'd0; BA = 3'd1;
        tick();
        check("lat_not_before_a", A_data, 16'h0000);
        check("lat_not_before_b", B_data, 16'h0000);
        RW = 1'b0; AA = 3'd5; BA = 3'd5;
        tick();
        check("lat_a", A_data, 16'hBEEF);
        check("lat_b", B_data, 16'hBEEF);

        // Bypass on port A only, port B reads a different register
        RW = 1'b1; DA = 3'd2; D_data = 16'h0001; tick();
        DA = 3'd4; D_data = 16'h0044; tick();
        DA = 3'd2; D_data = 16'h00F0; AA = 3'd2; BA = 3'd4;
        tick();
        check("byp_a", A_data, 16'h00F0);
        check("byp_b", B_data, 16'h0044);
        RW = 1'b0; AA = 3'd4; BA = 3'd2;
        tick();
        check("byp_r2_stored", B_data, 16'h00F0);
        check("byp_r4_kept", A_data, 16'h0044);

        // HOLD freezes outputs while writes continue
        RW = 1'b1; DA = 3'd1; D_data = 16'h1111; tick();
        DA = 3'd6; D_data = 16'h2222; tick();
        RW = 1'b0; AA = 3'd1; BA = 3'd6;
        tick();
        check("hold_pre_a", A_data, 16'h1111);
        check("hold_pre_b", B_data, 16'h2222);
        HOLD = 1'b1; RW = 1'b1; DA = 3'd1; D_data = 16'h7777;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_a", A_data, 16'h1111);
            check("hold_b", B_data, 16'h2222);
        end
        HOLD = 1'b0; RW = 1'b0;
        tick();
        check("hold_release_a", A_data, 16'h7777);
        check("hold_release_b", B_data, 16'h2222);

        // Register 0: writable normally, hard zero on the ZERO_R0 instance
        RW = 1'b1; DA = 3'd0; D_data = 16'hFFFF; AA = 3'd0; BA = 3'd0;
        tick();
        check("r0_z_bypass", A_data_z, 16'h0000);
        check("r0_norm_bypass", A_data, 16'hFFFF);
        RW = 1'b0;
        tick();
        check("r0_z_after", A_data_z, 16'h0000);
        check("r0_z_after_b", B_data_z, 16'h0000);
        check("r0_norm_after", A_data, 16'hFFFF);
        tick();
        check("r0_z_after2", A_data_z, 16'h0000);

        // Sweep all registers through both ports
        RW = 1'b1;
        for (int i = 0; i < 8; i++) begin
            DA = 3'(i); D_data = 16'(i * 16'h0101);
            tick();
        end
        RW = 1'b0;
        for (int i = 0; i < 8; i++) begin
            AA = 3'(i); BA = 3'(7 - i);
            tick();
            ea = 16'(i * 16'h0101);
            eb = 16'((7 - i) * 16'h0101);
            check("sweep_a", A_data, ea);
            check("sweep_b", B_data, eb);
            check("sweep_za", A_data_z, (i == 0) ? 16'h0000 : ea);
            check("sweep_zb", B_data_z, (i == 7) ? 16'h0000 : eb);
        end

        // RW=0 must not store
        RW = 1'b0; DA = 3'd3; D_data = 16'hABCD; AA = 3'd3; BA = 3'd3;
        tick();
        check("no_write_a", A_data, 16'h0303);
        tick();
        check("no_write_b", B_data, 16'h0303);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_ab.md
Name: register_file_ab

Overview:
- Dual-read, single-write general-purpose register file for the RISC-CPU datapath.
- Sits directly upstream of MUX_B and the A-bus select.
- Read port A drives A_data toward the A bus. Read port B drives B_data, the register operand input of MUX_B.
- Reads are registered (one-cycle latency), with write-to-read bypass so back-to-back dependent instructions see the newest value.

Parameters:
- WIDTH, 16, data width of each register and of every data port.
- ADDR_W, 3, register address width; register count is 2**ADDR_W (8).
- ZERO_R0, 0, when 1 register 0 reads as zero and ignores writes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- RW  input  1  write enable for the destination register.
- DA  input  ADDR_W  destination (write) address.
- D_data  input  WIDTH  write data from the D bus.
- AA  input  ADDR_W  read address, port A.
- BA  input  ADDR_W  read address, port B.
- HOLD  input  1  pipeline stall; freezes both read outputs.
- A_data  output  WIDTH  registered read data, port A.
- B_data  output  WIDTH  registered read data, port B; feeds MUX_B.

Behaviour:
- Reset
  - rst high clears all registers, A_data and B_data to 0 immediately, regardless of clk.
  - While rst is held, writes and reads are ignored.
  - After rst falls, the first rising edge performs normal operation.
- Write
  - On a rising edge with RW=1, D_data is stored in register DA.
  - With RW=0, no register changes.
  - When ZERO_R0=1 and DA=0, the write is discarded.
- Read, HOLD=0
  - On each rising edge, A_data loads the value of register AA and B_data loads the value of register BA.
  - Latency: the address presented in cycle n appears on the output after edge n, stable through cycle n+1.
- Bypass
  - If RW=1, DA==AA, and the write is not discarded, A_data loads D_data on the same edge.
  - Port B follows the same rule with BA.
  - Both ports may bypass in the same cycle (AA==BA==DA).
- ZERO_R0=1 reads: a read of address 0 always yields 0, including the bypass case.
- HOLD=1
  - A_data and B_data keep their previous values.
  - The register write still occurs.
  - When HOLD falls, the next edge loads the current contents, including any writes made during the stall.
- Simultaneous events
  - Read and write of the same address in one edge: the new value is returned (bypass).
  - Read of a different address is unaffected by the write.
- Reset mid-operation: an edge coincident with rst assertion performs no write; all state is 0.
- No X propagation: every output is defined from reset onward.

Test Plan:
1. Reset: write 0x1234 to R3, then assert rst for 1 ns between edges -> A_data=B_data=0 immediately; after release, a read of R3 returns 0x0000.
2. Write/read latency: RW=1, DA=5, D_data=0xBEEF at edge 1; RW=0, AA=5, BA=5 at edge 2 -> A_data=B_data=0xBEEF after edge 2, not before.
3. Bypass: R2=0x0001; at one edge RW=1, DA=2, D_data=0x00F0, AA=2, BA=4 (R4=0x0044) -> after the edge A_data=0x00F0, B_data=0x0044, R2=0x00F0.
4. HOLD: outputs A_data=0x1111, B_data=0x2222; HOLD=1 for 3 edges while writing 0x7777 to the addressed register -> outputs stay 0x1111/0x2222; HOLD=0 -> next edge shows 0x7777.
5. ZERO_R0=1 instance: RW=1, DA=0, D_data=0xFFFF, AA=0 -> A_data=0x0000 on that edge and all following edges.
6. Sweep: write i*0x0101 to R0..R7, then read AA=i, BA=7-i for i=0..7 -> each pair matches the written values one cycle after the address.
